// File: rtl/sobel_dma_pkg.sv
// Shared constants and types for the Sobel DMA writer.
package sobel_dma_pkg;

  localparam logic [1:0] OP_STATUS    = 2'd0;
  localparam logic [1:0] OP_SET_BASE  = 2'd1;
  localparam logic [1:0] OP_SET_COUNT = 2'd2;
  localparam logic [1:0] OP_ARM       = 2'd3;

  localparam int BURST_LEN  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam int FIFO_CW    = FIFO_AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    BEGIN,
    DATA,
    END
  } bus_state_t;

  // Status word bit positions.
  localparam int ST_ACTIVE    = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_BUSERR    = 3;
  localparam int ST_FIFO_LSB  = 4;
  localparam int ST_WORDS_LSB = 16;

  function automatic logic [31:0] pack_status(input logic [15:0]        words,
                                              input logic [FIFO_CW-1:0] count,
                                              input logic               bus_err,
                                              input logic               ovf,
                                              input logic               done,
                                              input logic               active);
    return {words, 7'b0, count, bus_err, ovf, done, active};
  endfunction

endpackage

// File: rtl/sobel_word_fifo.sv
// 16 x 32 synchronous FIFO with occupancy count and a flush that discards all entries.
module sobel_word_fifo
  import sobel_dma_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [31:0]        data_i,
  input  logic               pop_i,
  output logic [31:0]        data_o,
  output logic [FIFO_CW-1:0] count_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_CW-1:0] count_q;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count_q == FIFO_CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  // Storage array, written on accepted pushes.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sobel_dma_writer.sv
// Sobel DMA writer: packs edge pixels into 32-bit words and writes one frame as 8-beat bursts.
module sobel_dma_writer
  import sobel_dma_pkg::*;
#(
  parameter logic [7:0] customId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone,
  input  logic        frameStart,
  input  logic        pixelValid,
  input  logic [7:0]  pixelData,
  output logic        requestBus,
  input  logic        busGrant,
  output logic        beginTransactionOut,
  output logic [31:0] addressDataOut,
  output logic        endTransactionOut,
  output logic [3:0]  byteEnablesOut,
  output logic        dataValidOut,
  output logic [7:0]  burstSizeOut,
  input  logic        busyIn,
  input  logic        busErrorIn
);

  logic [31:0]        base_q;
  logic [15:0]        word_count_q;
  logic               armed_q, capturing_q, done_q, overflow_q, bus_err_q;
  logic               ci_done_q;
  logic [31:0]        ci_result_q;
  logic [31:0]        pack_q;
  logic [1:0]         pix_idx_q;
  logic               push_q;
  logic [15:0]        packed_q;
  bus_state_t         state_q;
  logic               req_q, begin_q, end_q, dvalid_q, err_q;
  logic [2:0]         beat_q;
  logic [31:0]        addr_q;
  logic [15:0]        words_written_q;
  logic [31:0]        fifo_head;
  logic [FIFO_CW-1:0] fifo_count;
  logic               fifo_full, fifo_empty, fifo_pop;

  logic        ci_hit, active, arm_fire, start_fire, pixel_take;
  logic        bus_err_evt, overflow_evt, frame_done_evt;
  logic [1:0]  ci_op;
  logic [31:0] status_w;
  logic        unused_bits;

  assign unused_bits    = ^{ciValueA[31:2], ciValueB[2:0], fifo_empty};
  assign ci_op          = ciValueA[1:0];
  assign ci_hit         = ciStart && (ciN == customId);
  assign active         = armed_q | capturing_q;
  assign arm_fire       = ci_hit && (ci_op == OP_ARM) && !active;
  assign start_fire     = frameStart && armed_q && !capturing_q;
  assign pixel_take     = capturing_q && pixelValid && (packed_q != word_count_q);
  assign bus_err_evt    = ((state_q == BEGIN) || (state_q == DATA)) && busErrorIn;
  assign fifo_pop       = dvalid_q && !busyIn;
  assign overflow_evt   = push_q && fifo_full && !fifo_pop && !bus_err_evt;
  assign frame_done_evt = capturing_q && (words_written_q == word_count_q);
  assign status_w       = pack_status(words_written_q, fifo_count, bus_err_q, overflow_q,
                                      done_q, active);

  assign ciDone              = ci_done_q;
  assign ciResult            = ci_result_q;
  assign requestBus          = req_q;
  assign beginTransactionOut = begin_q;
  assign endTransactionOut   = end_q;
  assign dataValidOut        = dvalid_q;
  assign byteEnablesOut      = begin_q ? 4'hF : 4'h0;
  assign burstSizeOut        = begin_q ? 8'(BURST_LEN - 1) : 8'd0;

  // Shared address/data lines: address in the begin cycle, FIFO head during beats.
  always_comb begin
    addressDataOut = '0;
    if (begin_q)       addressDataOut = addr_q;
    else if (dvalid_q) addressDataOut = fifo_head;
  end

  // Command decode and sticky flags; the result reflects state at the ciStart cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ci_done_q    <= 1'b0;
      ci_result_q  <= '0;
      base_q       <= '0;
      word_count_q <= '0;
      armed_q      <= 1'b0;
      capturing_q  <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      ci_done_q   <= ci_hit;
      ci_result_q <= '0;
      if (ci_hit) begin
        case (ci_op)
          OP_STATUS:    ci_result_q <= status_w;
          OP_SET_BASE:  if (!active) base_q <= {ciValueB[31:5], 5'b0};
          OP_SET_COUNT: if (!active) word_count_q <= {ciValueB[15:3], 3'b0};
          OP_ARM:       if (!active) ci_result_q <= 32'd1;
          default:      ci_result_q <= '0;
        endcase
      end
      if (arm_fire) begin
        armed_q    <= 1'b1;
        done_q     <= 1'b0;
        overflow_q <= 1'b0;
        bus_err_q  <= 1'b0;
      end
      if (start_fire) begin
        capturing_q <= 1'b1;
        armed_q     <= 1'b0;
      end
      if (overflow_evt) overflow_q <= 1'b1;
      if (bus_err_evt) begin
        bus_err_q   <= 1'b1;
        capturing_q <= 1'b0;
      end else if (frame_done_evt) begin
        done_q      <= 1'b1;
        capturing_q <= 1'b0;
      end
    end
  end

  // Packer: first pixel lands in bits [7:0]; the word is pushed the cycle after the fourth.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pack_q    <= '0;
      pix_idx_q <= '0;
      push_q    <= 1'b0;
      packed_q  <= '0;
    end else begin
      push_q <= 1'b0;
      if (bus_err_evt) begin
        pix_idx_q <= '0;
      end else if (arm_fire) begin
        pix_idx_q <= '0;
        packed_q  <= '0;
      end else if (pixel_take) begin
        pack_q    <= {pixelData, pack_q[31:8]};
        pix_idx_q <= pix_idx_q + 2'd1;
        if (pix_idx_q == 2'd3) begin
          push_q   <= 1'b1;
          packed_q <= packed_q + 16'd1;
        end
      end
    end
  end

  sobel_word_fifo u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush_i (bus_err_evt),
    .push_i  (push_q),
    .data_i  (pack_q),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Bus master: request, address phase, eight data beats, end strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      req_q           <= 1'b0;
      begin_q         <= 1'b0;
      end_q           <= 1'b0;
      dvalid_q        <= 1'b0;
      err_q           <= 1'b0;
      beat_q          <= '0;
      addr_q          <= '0;
      words_written_q <= '0;
    end else begin
      begin_q <= 1'b0;
      end_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fifo_count >= FIFO_CW'(BURST_LEN)) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (busGrant) begin
            state_q <= BEGIN;
            begin_q <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        BEGIN: begin
          if (busErrorIn) begin
            state_q <= END;
            end_q   <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q  <= DATA;
            dvalid_q <= 1'b1;
            beat_q   <= '0;
          end
        end
        DATA: begin
          if (busErrorIn) begin
            state_q  <= END;
            end_q    <= 1'b1;
            dvalid_q <= 1'b0;
            err_q    <= 1'b1;
          end else if (!busyIn) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'(BURST_LEN - 1)) begin
              state_q  <= END;
              end_q    <= 1'b1;
              dvalid_q <= 1'b0;
            end
          end
        end
        END: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          if (!err_q) begin
            addr_q          <= addr_q + 32'(BURST_LEN * 4);
            words_written_q <= words_written_q + 16'(BURST_LEN);
          end
        end
        default: state_q <= IDLE;
      endcase
      if (arm_fire) begin
        addr_q          <= base_q;
        words_written_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_dma_writer.sv
// Directed testbench for sobel_dma_writer.
module tb_sobel_dma_writer;

  localparam logic [7:0] ID = 8'h5A;

  logic        clock = 1'b0;
  logic        reset;
  logic        ciStart;
  logic [7:0]  ciN;
  logic [31:0] ciValueA, ciValueB;
  logic [31:0] ciResult;
  logic        ciDone;
  logic        frameStart, pixelValid;
  logic [7:0]  pixelData;
  logic        requestBus, busGrant, beginTransactionOut, endTransactionOut;
  logic [31:0] addressDataOut;
  logic [3:0]  byteEnablesOut;
  logic        dataValidOut;
  logic [7:0]  burstSizeOut;
  logic        busyIn, busErrorIn;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cycles = 0;
  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  int          mon_begin[$];
  int          mon_end[$];

  sobel_dma_writer #(.customId(ID)) dut (
    .clock               (clock),
    .reset               (reset),
    .ciStart             (ciStart),
    .ciN                 (ciN),
    .ciValueA            (ciValueA),
    .ciValueB            (ciValueB),
    .ciResult            (ciResult),
    .ciDone              (ciDone),
    .frameStart          (frameStart),
    .pixelValid          (pixelValid),
    .pixelData           (pixelData),
    .requestBus          (requestBus),
    .busGrant            (busGrant),
    .beginTransactionOut (beginTransactionOut),
    .addressDataOut      (addressDataOut),
    .endTransactionOut   (endTransactionOut),
    .byteEnablesOut      (byteEnablesOut),
    .dataValidOut        (dataValidOut),
    .burstSizeOut        (burstSizeOut),
    .busyIn              (busyIn),
    .busErrorIn          (busErrorIn)
  );

  always #5 clock = ~clock;

  // Bus monitor: records address phases, completed beats and end strobes.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (beginTransactionOut) begin
      mon_addr.push_back(addressDataOut);
      mon_begin.push_back(cyc);
    end
    if (dataValidOut && !busyIn) mon_data.push_back(addressDataOut);
    if (endTransactionOut) mon_end.push_back(cyc);
    if (requestBus) req_cycles <= req_cycles + 1;
  end

  function automatic logic [31:0] exp_word(input int i);
    return {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    ciStart    = 1'b0;
    ciN        = 8'd0;
    ciValueA   = '0;
    ciValueB   = '0;
    frameStart = 1'b0;
    pixelValid = 1'b0;
    pixelData  = '0;
    busGrant   = 1'b1;
    busyIn     = 1'b0;
    busErrorIn = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    mon_addr.delete();
    mon_data.delete();
    mon_begin.delete();
    mon_end.delete();
  endtask

  task automatic ci_op(input logic [1:0] op, input logic [31:0] val,
                       output logic [31:0] res, output logic dn);
    ciStart  = 1'b1;
    ciN      = ID;
    ciValueA = {30'd0, op};
    ciValueB = val;
    tick();
    ciStart  = 1'b0;
    ciValueA = '0;
    ciValueB = '0;
    res = ciResult;
    dn  = ciDone;
  endtask

  task automatic program_and_arm(input logic [31:0] base, input logic [31:0] count);
    logic [31:0] r;
    logic        d;
    ci_op(2'd1, base, r, d);
    ci_op(2'd2, count, r, d);
    ci_op(2'd3, 32'd0, r, d);
  endtask

  task automatic frame_start();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      pixelValid = 1'b1;
      pixelData  = 8'(i);
      tick();
    end
    pixelValid = 1'b0;
  endtask

  task automatic wait_ends(input int n, input int bound, input string name);
    int k;
    k = 0;
    while (mon_end.size() < n && k < bound) begin
      tick();
      k++;
    end
    checks++;
    if (mon_end.size() < n) begin
      errors++;
      $display("FAIL %s: end strobes seen %0d, required %0d", name, mon_end.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic        d;
    reset = 1'b1;
    ciStart = 1'b0; ciN = 8'd0; ciValueA = '0; ciValueB = '0;
    frameStart = 1'b0; pixelValid = 1'b0; pixelData = '0;
    busGrant = 1'b1; busyIn = 1'b0; busErrorIn = 1'b0;
    #1;
    checks++;
    if ({ciResult, ciDone, requestBus, beginTransactionOut, addressDataOut, endTransactionOut,
         byteEnablesOut, dataValidOut, burstSizeOut} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs (ciDone=%b req=%b ad=%h), required all 0",
               ciDone, requestBus, addressDataOut);
    end
    tick();
    reset = 1'b0;
    tick();
    ciStart = 1'b1; ciN = ID + 8'd1; ciValueA = '0;
    tick();
    ciStart = 1'b0;
    checks++;
    if (ciDone !== 1'b0) begin
      errors++;
      $display("FAIL wrong_id_done: got %b, required 0", ciDone);
    end
    ci_op(2'd0, 32'd0, r, d);
    checks++;
    if (d !== 1'b1 || r !== 32'd0) begin
      errors++;
      $display("FAIL reset_status: got done=%b result=%h, required done=1 result=00000000", d, r);
    end
  endtask

  task automatic test_frame();
    logic [31:0] r;
    logic        d;
    do_reset();
    ci_op(2'd1, 32'h1000, r, d);
    checks++;
    if (d !== 1'b1 || r !== 32'd0) begin
      errors++;
      $display("FAIL set_base_ack: got done=%b result=%h, required done=1 result=0", d, r);
    end
    ci_op(2'd2, 32'd16, r, d);
    ci_op(2'd3, 32'd0, r, d);
    checks++;
    if (r !== 32'd1) begin
      errors++;
      $display("FAIL arm_result: got %h, required 00000001", r);
    end
    frame_start();
    send_pixels(64);
    wait_ends(2, 300, "frame_ends");
    repeat (3) tick();
    checks++;
    if (mon_addr.size() != 2 || mon_addr[0] !== 32'h1000 || mon_addr[1] !== 32'h1020) begin
      errors++;
      $display("FAIL frame_addr: got %0d bursts first %h, required 2 bursts 00001000/00001020",
               mon_addr.size(), (mon_addr.size() > 0) ? mon_addr[0] : 32'hx);
    end
    checks++;
    if (mon_data.size() != 16) begin
      errors++;
      $display("FAIL frame_beats: got %0d, required 16", mon_data.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (mon_data[i] !== exp_word(i)) begin
          errors++;
          $display("FAIL frame_data[%0d]: got %h, required %h", i, mon_data[i], exp_word(i));
        end
      end
    end
    checks++;
    if (mon_begin.size() < 1 || mon_end.size() < 1 || mon_end[0] - mon_begin[0] + 1 != 10) begin
      errors++;
      $display("FAIL frame_burst_len: got %0d cycles, required 10",
               (mon_end.size() > 0 && mon_begin.size() > 0) ? mon_end[0] - mon_begin[0] + 1 : -1);
    end
    ci_op(2'd0, 32'd0, r, d);
    checks++;
    if (r !== 32'h0010_0002) begin
      errors++;
      $display("FAIL frame_status: got %h, required 00100002", r);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    bit          hit;
    do_reset();
    program_and_arm(32'h1000, 32'd16);
    frame_start();
    hit = 0;
    fork
      send_pixels(64);
      begin
        for (int k = 0; k < 300 && !hit; k++) begin
          if (dataValidOut && mon_data.size() == 3) begin
            hit    = 1;
            held   = addressDataOut;
            busyIn = 1'b1;
            for (int s = 0; s < 3; s++) begin
              tick();
              checks++;
              if (dataValidOut !== 1'b1 || addressDataOut !== held) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got dv=%b data=%h, required dv=1 data=%h",
                         s, dataValidOut, addressDataOut, held);
              end
            end
            busyIn = 1'b0;
          end else begin
            tick();
          end
        end
        checks++;
        if (!hit) begin
          errors++;
          $display("FAIL stall_beat4: got no 4th beat, required one within 300 cycles");
        end
      end
    join
    wait_ends(2, 300, "stall_ends");
    checks++;
    if (mon_end.size() < 1 || mon_begin.size() < 1 || mon_end[0] - mon_begin[0] + 1 != 13) begin
      errors++;
      $display("FAIL stall_burst_len: got %0d cycles, required 13",
               (mon_end.size() > 0 && mon_begin.size() > 0) ? mon_end[0] - mon_begin[0] + 1 : -1);
    end
    checks++;
    if (mon_data.size() != 16) begin
      errors++;
      $display("FAIL stall_beats: got %0d, required 16", mon_data.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (mon_data[i] !== exp_word(i)) begin
          errors++;
          $display("FAIL stall_data[%0d]: got %h, required %h", i, mon_data[i], exp_word(i));
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    logic        d;
    do_reset();
    program_and_arm(32'h4000, 32'd32);
    busGrant = 1'b0;
    frame_start();
    send_pixels(128);
    repeat (12) tick();
    checks++;
    if (requestBus !== 1'b1 || mon_begin.size() != 0) begin
      errors++;
      $display("FAIL ovf_waiting: got req=%b begins=%0d, required req=1 begins=0",
               requestBus, mon_begin.size());
    end
    ci_op(2'd0, 32'd0, r, d);
    checks++;
    if (r !== 32'h0000_0105) begin
      errors++;
      $display("FAIL ovf_status: got %h, required 00000105", r);
    end
    busGrant = 1'b1;
    wait_ends(2, 200, "ovf_ends");
    repeat (40) tick();
    checks++;
    if (mon_begin.size() != 2 || mon_addr[0] !== 32'h4000 || mon_addr[1] !== 32'h4020) begin
      errors++;
      $display("FAIL ovf_bursts: got %0d bursts, required 2 at 00004000/00004020",
               mon_begin.size());
    end
    checks++;
    if (mon_data.size() != 16) begin
      errors++;
      $display("FAIL ovf_beats: got %0d, required 16", mon_data.size());
    end else begin
      for (int i = 0; i < 16; i += 5) begin
        checks++;
        if (mon_data[i] !== exp_word(i)) begin
          errors++;
          $display("FAIL ovf_data[%0d]: got %h, required %h", i, mon_data[i], exp_word(i));
        end
      end
    end
    ci_op(2'd0, 32'd0, r, d);
    checks++;
    if (r !== 32'h0010_0005) begin
      errors++;
      $display("FAIL ovf_status_after: got %h, required 00100005", r);
    end
  endtask

  task automatic test_bus_error();
    logic [31:0] r;
    logic        d;
    bit          hit;
    do_reset();
    program_and_arm(32'h2000, 32'd16);
    frame_start();
    hit = 0;
    fork
      send_pixels(64);
      begin
        for (int k = 0; k < 300 && !hit; k++) begin
          if (dataValidOut && mon_data.size() == 1) begin
            hit        = 1;
            busErrorIn = 1'b1;
            tick();
            busErrorIn = 1'b0;
            checks++;
            if (endTransactionOut !== 1'b1 || dataValidOut !== 1'b0) begin
              errors++;
              $display("FAIL err_end: got end=%b dv=%b, required end=1 dv=0",
                       endTransactionOut, dataValidOut);
            end
            tick();
            req_cycles = 0;
          end else begin
            tick();
          end
        end
        checks++;
        if (!hit) begin
          errors++;
          $display("FAIL err_beat2: got no 2nd beat, required one within 300 cycles");
        end
      end
    join
    repeat (60) tick();
    checks++;
    if (req_cycles != 0 || mon_begin.size() != 1) begin
      errors++;
      $display("FAIL err_no_more_req: got req cycles=%0d begins=%0d, required 0 and 1",
               req_cycles, mon_begin.size());
    end
    ci_op(2'd0, 32'd0, r, d);
    checks++;
    if (r !== 32'h0000_0008) begin
      errors++;
      $display("FAIL err_status: got %h, required 00000008", r);
    end
  endtask

  task automatic test_cmd_guard();
    logic [31:0] r;
    logic        d;
    do_reset();
    program_and_arm(32'h300F, 32'd8);
    frame_start();
    ciStart = 1'b1; ciN = ID; ciValueA = 32'd1; ciValueB = 32'h5000;
    tick();
    checks++;
    if (ciDone !== 1'b1 || ciResult !== 32'd0) begin
      errors++;
      $display("FAIL guard_base_ack: got done=%b result=%h, required done=1 result=0",
               ciDone, ciResult);
    end
    ciValueA = 32'd3; ciValueB = 32'd0;
    tick();
    checks++;
    if (ciDone !== 1'b1 || ciResult !== 32'd0) begin
      errors++;
      $display("FAIL guard_arm_ack: got done=%b result=%h, required done=1 result=0",
               ciDone, ciResult);
    end
    ciStart = 1'b0; ciValueA = '0;
    tick();
    checks++;
    if (ciDone !== 1'b0) begin
      errors++;
      $display("FAIL guard_done_drop: got %b, required 0", ciDone);
    end
    ci_op(2'd0, 32'd0, r, d);
    checks++;
    if (r !== 32'h0000_0001) begin
      errors++;
      $display("FAIL guard_status_capt: got %h, required 00000001", r);
    end
    send_pixels(32);
    wait_ends(1, 200, "guard_ends");
    repeat (3) tick();
    checks++;
    if (mon_addr.size() != 1 || mon_addr[0] !== 32'h3000) begin
      errors++;
      $display("FAIL guard_base_kept: got %0d bursts first %h, required 1 burst at 00003000",
               mon_addr.size(), (mon_addr.size() > 0) ? mon_addr[0] : 32'hx);
    end
    ci_op(2'd0, 32'd0, r, d);
    checks++;
    if (r !== 32'h0008_0002) begin
      errors++;
      $display("FAIL guard_status_done: got %h, required 00080002", r);
    end
  endtask

  task automatic test_zero_count();
    logic [31:0] r;
    logic        d;
    do_reset();
    program_and_arm(32'h0, 32'd5);
    frame_start();
    repeat (2) tick();
    ci_op(2'd0, 32'd0, r, d);
    checks++;
    if (r !== 32'h0000_0002) begin
      errors++;
      $display("FAIL zero_count_status: got %h, required 00000002", r);
    end
  endtask

  task automatic test_reset_midburst();
    logic [31:0] r;
    logic        d;
    bit          hit;
    do_reset();
    program_and_arm(32'h1000, 32'd16);
    frame_start();
    hit = 0;
    fork
      send_pixels(64);
      begin
        for (int k = 0; k < 300 && !hit; k++) begin
          if (dataValidOut) begin
            hit = 1;
            #2;
            reset = 1'b1;
            #1;
            checks++;
            if ({requestBus, beginTransactionOut, endTransactionOut, dataValidOut,
                 byteEnablesOut, burstSizeOut, addressDataOut} !== '0) begin
              errors++;
              $display("FAIL rst_bus_outputs: got req=%b dv=%b end=%b ad=%h, required all 0",
                       requestBus, dataValidOut, endTransactionOut, addressDataOut);
            end
            tick();
            reset = 1'b0;
          end else begin
            tick();
          end
        end
        checks++;
        if (!hit) begin
          errors++;
          $display("FAIL rst_no_beat: got no data beat, required one within 300 cycles");
        end
      end
    join
    tick();
    ci_op(2'd0, 32'd0, r, d);
    checks++;
    if (d !== 1'b1 || r !== 32'd0) begin
      errors++;
      $display("FAIL rst_status: got done=%b result=%h, required done=1 result=00000000", d, r);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_overflow();
    test_bus_error();
    test_cmd_guard();
    test_zero_count();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_dma_writer.md
# sobel_dma_writer

- Downstream stage of the Sobel filter: takes its 8-bit edge-magnitude pixel stream, packs four pixels per 32-bit word, buffers the words, and writes one frame to memory as 8-word bus bursts.
- Software controls it through the custom-instruction port: it sets the base address and frame length, arms a capture, then polls status.

## Interface
Parameters:
- customId, 8'd0, custom-instruction id this block answers to

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high
- ciStart  in  1  custom-instruction strobe
- ciN  in  8  instruction id; acted on only when equal to customId
- ciValueA  in  32  [1:0] opcode: 0 status, 1 set base, 2 set word count, 3 arm
- ciValueB  in  32  operand
- ciResult  out  32  result; 0 when ciDone low
- ciDone  out  1  instruction complete
- frameStart  in  1  one-cycle pulse at start of a filtered frame
- pixelValid  in  1  pixelData valid this cycle
- pixelData  in  8  edge magnitude
- requestBus  out  1  bus request
- busGrant  in  1  bus granted
- beginTransactionOut  out  1  address phase strobe
- addressDataOut  out  32  address in begin cycle, data in beats, else 0
- endTransactionOut  out  1  transaction end strobe
- byteEnablesOut  out  4  4'hF in begin cycle, else 0
- dataValidOut  out  1  data beat valid
- burstSizeOut  out  8  8'd7 (beats−1) in begin cycle, else 0
- busyIn  in  1  slave stall
- busErrorIn  in  1  bus error

## Operation
- **Registers:**
  - base (32b, low 5 bits forced 0).
  - wordCount (16b, low 3 bits forced 0; value 0 means the frame completes immediately).
  - Sticky flags: armed, capturing, done, overflow, busErr.
- **Op 0 (status):** returns {wordsWritten[15:0], 7'b0, fifoCount[4:0], busErr, overflow, done, armed|capturing}.
- **Op 1 / op 2:** write base / wordCount. Ignored while armed or capturing. Result is 0.
- **Op 3 (arm):**
  - Ignored while armed or capturing.
  - Otherwise it sets armed, clears done/overflow/busErr and wordsWritten, loads the address counter from base, and returns 1.
- **Frame start:** frameStart while armed (and not capturing) sets capturing and clears armed. A frameStart while capturing is ignored.
- **Packing:**
  - While capturing, each pixelValid pixel enters the packer little-endian (first pixel in bits [7:0]).
  - The fourth pixel completes a word, which is pushed to the FIFO.
  - Pixels after wordCount words have been packed are discarded.
- **Overflow:** if the FIFO is full when a word is pushed, the word is dropped, overflow is set, and the word still counts toward wordCount.
- **Bus FSM:**
  - IDLE → REQ when fifoCount ≥ 8. requestBus is high in REQ.
  - REQ → BEGIN on busGrant.
  - BEGIN, one cycle: beginTransactionOut, address, byteEnablesOut, burstSizeOut driven.
  - DATA: dataValidOut=1 with the FIFO head. A beat completes and pops when busyIn=0. After the 8th beat → END.
  - END, one cycle: endTransactionOut. Then address += 32, wordsWritten += 8 → IDLE.
  - requestBus stays high from REQ through END.
- **Bus error:** busErrorIn in BEGIN or DATA → END next cycle.
  - Sets busErr, clears capturing, flushes the FIFO and packer.
  - Nothing more is written.
- **Frame complete:** when wordsWritten reaches wordCount, done is set and capturing is cleared.
- **Reset:** all outputs 0, FSM IDLE, FIFO empty, all registers and flags 0.

## Timing
- ciDone is registered: high exactly one cycle, the cycle after a matching ciStart.
  - ciResult is valid in that same cycle and sampled from the state at ciStart.
  - Back-to-back ciStart gives back-to-back ciDone.
- FIFO push occurs in the cycle after the 4th pixel is sampled.
- fifoCount ≥ 8 in IDLE → requestBus high the next cycle.
- busGrant sampled high → BEGIN the next cycle. The first DATA beat follows BEGIN.
- With busyIn=0 throughout, a transaction is 10 cycles from BEGIN to END.
- busyIn=1 holds dataValidOut and the data unchanged and adds one cycle per stalled cycle.
- A push and a pop in the same cycle leave fifoCount unchanged. A push into a full FIFO that pops in the same cycle is accepted, not dropped.
- An asynchronous reset mid-burst drops all bus outputs immediately, with no endTransactionOut.

## Structure
- Package sobel_dma_pkg holds:
  - Opcode constants OP_STATUS, OP_SET_BASE, OP_SET_COUNT, OP_ARM.
  - BURST_LEN=8 and FIFO_DEPTH=16.
  - Bus FSM state encodings IDLE, REQ, BEGIN, DATA, END.
  - Status bit positions.
- One sub-module: sobel_word_fifo, a 16×32 synchronous FIFO with count, full and empty outputs.
- Packer, control registers and bus FSM live in the top block.

## Test plan
1. **Programming and normal frame:** op1 base=0x1000, op2 count=16, op3 arm, frameStart, then 64 pixels 0x00..0x3F with busGrant tied 1 and busyIn 0.
   - Two bursts, at 0x1000 and 0x1020.
   - First beat 0x03020100, last 0x3F3E3D3C.
   - Status = 0x0010_0002.
2. **Stall:** same frame with busyIn high for 3 cycles on beat 4.
   - dataValidOut and the data are held.
   - END comes 13 cycles after BEGIN.
   - Data is unchanged.
3. **Overflow:** count=32, busGrant held 0 for 100 cycles while 128 pixels stream.
   - FIFO holds 16 words; the remaining 16 are dropped.
   - Status overflow bit is 1.
   - After grant, exactly 2 bursts are written.
4. **Bus error:** busErrorIn=1 on beat 2.
   - endTransactionOut the next cycle.
   - busErr=1, FIFO flushed, no further requestBus.
5. **Command guards:** op1 and op3 issued while capturing.
   - base is unchanged.
   - op3 returns 0.
   - ciDone is high one cycle after each ciStart.
6. **Reset mid-burst:** reset during DATA.
   - All bus outputs 0 asynchronously.
   - Status reads 0 after release.
